// File: rtl/tile_pkg.sv
// Shared constants, row type and lane decode for the tile lane sequencer.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package tile_pkg;

  localparam int NUM_LANES   = 4;
  localparam int DEPTH       = 4;
  localparam int CNT_W       = 26;
  localparam int PERIOD_INIT = 25000000;
  localparam int PERIOD_MIN  = 5000000;
  localparam int PERIOD_STEP = 250000;

  // Widest lane count the decode helper can represent.
  localparam int MAX_LANES   = 32;

  typedef logic [NUM_LANES-1:0] row_t;

  // One-hot lane decode; values outside the lane range give an all-zero gap row.
  function automatic logic [MAX_LANES-1:0] lane_to_onehot(input int unsigned ran,
                                                         input int unsigned lanes = NUM_LANES);
    logic [MAX_LANES-1:0] oh;
    oh = '0;
    if (ran < lanes) begin
      oh = MAX_LANES'(1) << ran;
    end
    return oh;
  endfunction

endpackage

// File: rtl/tile_period_timer.sv
// Row period timer: counts 0..period-1 and shortens the period after every row.
// Latency: tick is combinational from the count; the new period applies from the next interval.
// Backpressure: en=0 freezes the count and period; restart reloads regardless of en.
module tile_period_timer #(
  parameter int CNT_W       = tile_pkg::CNT_W,
  parameter int PERIOD_INIT = tile_pkg::PERIOD_INIT,
  parameter int PERIOD_MIN  = tile_pkg::PERIOD_MIN,
  parameter int PERIOD_STEP = tile_pkg::PERIOD_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  output logic             tick,
  output logic [CNT_W-1:0] period
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   diff;
  logic [CNT_W-1:0] next_period;

  // Saturating decrement; the extra bit catches a borrow when the step exceeds the period.
  always_comb begin
    diff = {1'b0, period} - (CNT_W+1)'(PERIOD_STEP);
    if (diff[CNT_W] || (diff[CNT_W-1:0] < CNT_W'(PERIOD_MIN))) begin
      next_period = CNT_W'(PERIOD_MIN);
    end else begin
      next_period = diff[CNT_W-1:0];
    end
  end

  assign tick = en && (cnt == (period - CNT_W'(1)));

  // Count within the interval; on the last count wrap and load the shorter period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      period <= CNT_W'(PERIOD_INIT);
    end else if (restart) begin
      cnt    <= '0;
      period <= CNT_W'(PERIOD_INIT);
    end else if (tick) begin
      cnt    <= '0;
      period <= next_period;
    end else if (en) begin
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tile_lane_sequencer.sv
// Tile row generator: one one-hot (or gap) row per period, DEPTH-row scrolling history.
// Latency: ran is sampled on the tick edge; state, rows and state_change update on that same edge.
// Backpressure: en=0 holds all state; restart clears the game and wins over a tick.
// Optional feature macro: TILE_NO_REPEAT_EN (rotate a lane that would repeat the previous row).
module tile_lane_sequencer #(
  parameter int NUM_LANES   = tile_pkg::NUM_LANES,
  parameter int RAND_W      = 3,
  parameter int DEPTH       = tile_pkg::DEPTH,
  parameter int CNT_W       = tile_pkg::CNT_W,
  parameter int PERIOD_INIT = tile_pkg::PERIOD_INIT,
  parameter int PERIOD_MIN  = tile_pkg::PERIOD_MIN,
  parameter int PERIOD_STEP = tile_pkg::PERIOD_STEP
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       restart,
  input  logic [RAND_W-1:0]          ran,
  output logic [NUM_LANES-1:0]       state,
  output logic [NUM_LANES*DEPTH-1:0] rows,
  output logic                       state_change,
  output logic [CNT_W-1:0]           period,
  output logic [15:0]                row_count
);

  import tile_pkg::*;

  logic                 tick;
  logic [NUM_LANES-1:0] newrow;

  tile_period_timer #(
    .CNT_W       (CNT_W),
    .PERIOD_INIT (PERIOD_INIT),
    .PERIOD_MIN  (PERIOD_MIN),
    .PERIOD_STEP (PERIOD_STEP)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .restart (restart),
    .tick    (tick),
    .period  (period)
  );

`ifdef TILE_NO_REPEAT_EN
  logic [NUM_LANES-1:0] raw_row;

  // Decode the lane; a lane equal to the previous row moves on to the next lane.
  always_comb begin
    raw_row = NUM_LANES'(lane_to_onehot(32'(ran), NUM_LANES));
    newrow  = raw_row;
    if ((raw_row != '0) && (raw_row == state)) begin
      newrow = NUM_LANES'(lane_to_onehot((32'(ran) + 32'd1) % 32'(NUM_LANES), NUM_LANES));
    end
  end
`else
  // Decode the lane directly; repeats of the previous lane are allowed.
  always_comb begin
    newrow = NUM_LANES'(lane_to_onehot(32'(ran), NUM_LANES));
  end
`endif

  // Row history, newest row, pulse and row counter all move together on a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= '0;
      rows         <= '0;
      state_change <= 1'b0;
      row_count    <= '0;
    end else if (restart) begin
      state        <= '0;
      rows         <= '0;
      state_change <= 1'b0;
      row_count    <= '0;
    end else if (tick) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        rows[i*NUM_LANES +: NUM_LANES] <= rows[(i-1)*NUM_LANES +: NUM_LANES];
      end
      rows[NUM_LANES-1:0] <= newrow;
      state               <= newrow;
      state_change        <= 1'b1;
      if (row_count != 16'hFFFF) begin
        row_count <= row_count + 16'd1;
      end
    end else begin
      state_change <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tile_lane_sequencer.sv
// Directed bench for tile_lane_sequencer: expected rows queued by stimulus, checked by a monitor.
// Small configuration: 4 lanes, 3-row history, period 8 shrinking by 2 down to 4.
// Honours TILE_NO_REPEAT_EN for the repeated-lane expectation.
module tb_tile_lane_sequencer;

  localparam int NL    = 4;
  localparam int RW    = 3;
  localparam int DP    = 3;
  localparam int CW    = 8;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            restart;
  logic [RW-1:0]   ran;
  logic [NL-1:0]   state;
  logic [NL*DP-1:0] rows;
  logic            state_change;
  logic [CW-1:0]   period;
  logic [15:0]     row_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0]  st;
    logic [11:0] rw;
    logic [7:0]  per;
    logic [15:0] rc;
    int          at;
  } exp_t;

  exp_t exp_q[$];

  tile_lane_sequencer #(
    .NUM_LANES   (NL),
    .RAND_W      (RW),
    .DEPTH       (DP),
    .CNT_W       (CW),
    .PERIOD_INIT (8),
    .PERIOD_MIN  (4),
    .PERIOD_STEP (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .restart      (restart),
    .ran          (ran),
    .state        (state),
    .rows         (rows),
    .state_change (state_change),
    .period       (period),
    .row_count    (row_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic [11:0] rw, input logic [7:0] per,
                      input logic [15:0] rc, input int at);
    exp_t e;
    e.st = st; e.rw = rw; e.per = per; e.rc = rc; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_sc();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!state_change && n < 40);
    if (!state_change) begin
      total++;
      bad++;
      $display("FAIL sc_timeout: no state_change within %0d cycles (cycle %0d)", n, cyc);
    end
  endtask

  // Monitor: every pulse must match the next queued row, including its cycle.
  always @(negedge clk) begin
    if (rst_n && state_change) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_sc: pulse with nothing expected (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sc_cycle",  32'(cyc),       32'(e.at));
        chk("state",     32'(state),     32'(e.st));
        chk("rows",      32'(rows),      32'(e.rw));
        chk("period",    32'(period),    32'(e.per));
        chk("row_count", 32'(row_count), 32'(e.rc));
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    restart = 1'b0;
    ran     = 3'd2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    chk("rst_state",  32'(state),        32'h0);
    chk("rst_rows",   32'(rows),         32'h0);
    chk("rst_sc",     32'(state_change), 32'h0);
    chk("rst_period", 32'(period),       32'd8);
    chk("rst_rc",     32'(row_count),    32'd0);

    // Rows at intervals 8, 6, 4, 4 then flat at the floor.
    push(4'b0100, 12'h004, 8'd6, 16'd1, 8);
    wait_sc();
    ran = 3'd0; push(4'b0001, 12'h041, 8'd4, 16'd2, 14);
    wait_sc();
    ran = 3'd1; push(4'b0010, 12'h412, 8'd4, 16'd3, 18);
    wait_sc();
    ran = 3'd2; push(4'b0100, 12'h124, 8'd4, 16'd4, 22);
    wait_sc();
    // Out-of-range lane gives a gap row.
    ran = 3'd5; push(4'b0000, 12'h240, 8'd4, 16'd5, 26);
    wait_sc();
    ran = 3'd3; push(4'b1000, 12'h408, 8'd4, 16'd6, 30);
    wait_sc();

    // Pause 10 cycles mid-interval: tick moves from 34 to 44.
    ran = 3'd1;
    push(4'b0010, 12'h082, 8'd4, 16'd7, 44);
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    wait_sc();

    // Same lane again.
`ifdef TILE_NO_REPEAT_EN
    push(4'b0100, 12'h824, 8'd4, 16'd8, 48);
`else
    push(4'b0010, 12'h822, 8'd4, 16'd8, 48);
`endif
    wait_sc();

    // Restart held across the tick edge at 52: no row, full clear.
    ran = 3'd3;
    repeat (3) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs_sc",     32'(state_change), 32'h0);
    chk("rs_state",  32'(state),        32'h0);
    chk("rs_rows",   32'(rows),         32'h0);
    chk("rs_period", 32'(period),       32'd8);
    chk("rs_rc",     32'(row_count),    32'd0);
    push(4'b1000, 12'h008, 8'd6, 16'd1, 60);
    wait_sc();

    // Asynchronous reset mid-interval clears everything at once.
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_state",  32'(state),     32'h0);
    chk("ar_rows",   32'(rows),      32'h0);
    chk("ar_period", 32'(period),    32'd8);
    chk("ar_rc",     32'(row_count), 32'd0);
    chk("pending",   32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
